// File: rtl/video_timing_pkg.sv
// Shared video timing defaults (640x480@60 style), total-period helper,
// RGB565 field positions and the sync/active control word carried down the pipe.
package video_timing_pkg;

    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;

    localparam int RED_MSB = 15;
    localparam int RED_LSB = 11;
    localparam int GRN_MSB = 10;
    localparam int GRN_LSB = 5;
    localparam int BLU_MSB = 4;
    localparam int BLU_LSB = 0;

    function automatic int timing_total(input int visible, input int front,
                                        input int sync, input int back);
        return visible + front + sync + back;
    endfunction

    localparam int H_TOTAL_DEF = timing_total(H_VISIBLE_DEF, H_FRONT_DEF, H_SYNC_DEF, H_BACK_DEF);
    localparam int V_TOTAL_DEF = timing_total(V_VISIBLE_DEF, V_FRONT_DEF, V_SYNC_DEF, V_BACK_DEF);

    typedef struct packed {
        logic active;
        logic hsync;
        logic vsync;
    } scan_ctl_t;

    // Blanked region, syncs idle high.
    localparam scan_ctl_t SCAN_CTL_IDLE = '{active: 1'b0, hsync: 1'b1, vsync: 1'b1};

endpackage

// File: rtl/video_delay_line.sv
// Pixel-tick qualified shift line of DEPTH stages; DEPTH=0 is a straight wire.
module video_delay_line #(
    parameter int               DEPTH       = 1,
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pix_en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic unused_s;
            assign unused_s = &{1'b0, clk, reset, pix_en};
            assign dout     = din;
        end else begin : g_shift
            logic [WIDTH-1:0] stage_r [DEPTH];

            // Shift one stage per pixel tick, hold otherwise.
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_r[i] <= RESET_VALUE;
                    end
                end else if (pix_en) begin
                    stage_r[0] <= din;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_r[i] <= stage_r[i-1];
                    end
                end
            end

            assign dout = stage_r[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/video_scan.sv
// Raster scan generator with renderer-latency compensated color/sync outputs.
// Optional frame counter enabled by defining VIDEO_SCAN_FRAME_COUNTER_EN.
module video_scan
    import video_timing_pkg::*;
#(
    parameter int H_VISIBLE    = H_VISIBLE_DEF,
    parameter int H_FRONT      = H_FRONT_DEF,
    parameter int H_SYNC       = H_SYNC_DEF,
    parameter int H_BACK       = H_BACK_DEF,
    parameter int V_VISIBLE    = V_VISIBLE_DEF,
    parameter int V_FRONT      = V_FRONT_DEF,
    parameter int V_SYNC       = V_SYNC_DEF,
    parameter int V_BACK       = V_BACK_DEF,
    parameter int COORD_WIDTH  = 10,
    parameter int PIPE_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pix_en,
    output logic [COORD_WIDTH-1:0] x_coord,
    output logic [COORD_WIDTH-1:0] y_coord,
    input  logic [15:0]            color_in,
    output logic                   frame_start,
    output logic [4:0]             vga_r,
    output logic [5:0]             vga_g,
    output logic [4:0]             vga_b,
    output logic                   hsync,
    output logic                   vsync,
    output logic [15:0]            frame_count
);

    localparam int H_TOTAL = timing_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = timing_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

    localparam logic [COORD_WIDTH-1:0] CNT_ONE  = COORD_WIDTH'(1);
    localparam logic [COORD_WIDTH-1:0] H_VIS_C  = COORD_WIDTH'(H_VISIBLE);
    localparam logic [COORD_WIDTH-1:0] H_SYN_LO = COORD_WIDTH'(H_VISIBLE + H_FRONT);
    localparam logic [COORD_WIDTH-1:0] H_SYN_HI = COORD_WIDTH'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [COORD_WIDTH-1:0] H_LAST   = COORD_WIDTH'(H_TOTAL - 1);
    localparam logic [COORD_WIDTH-1:0] V_VIS_C  = COORD_WIDTH'(V_VISIBLE);
    localparam logic [COORD_WIDTH-1:0] V_SYN_LO = COORD_WIDTH'(V_VISIBLE + V_FRONT);
    localparam logic [COORD_WIDTH-1:0] V_SYN_HI = COORD_WIDTH'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [COORD_WIDTH-1:0] V_LAST   = COORD_WIDTH'(V_TOTAL - 1);
    localparam logic [COORD_WIDTH-1:0] V_PRE_VB = COORD_WIDTH'(V_VISIBLE - 1);

    logic [COORD_WIDTH-1:0] h_cnt_r;
    logic [COORD_WIDTH-1:0] v_cnt_r;
    scan_ctl_t              raw_ctl_s;
    scan_ctl_t              dly_ctl_s;
    logic                   vblank_entry_s;

    // Horizontal/vertical raster counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt_r <= '0;
            v_cnt_r <= '0;
        end else if (pix_en) begin
            if (h_cnt_r == H_LAST) begin
                h_cnt_r <= '0;
                if (v_cnt_r == V_LAST) begin
                    v_cnt_r <= '0;
                end else begin
                    v_cnt_r <= v_cnt_r + CNT_ONE;
                end
            end else begin
                h_cnt_r <= h_cnt_r + CNT_ONE;
            end
        end
    end

    assign x_coord = h_cnt_r;
    assign y_coord = v_cnt_r;

    // Raw region decode from the current counter position.
    always_comb begin
        raw_ctl_s        = SCAN_CTL_IDLE;
        raw_ctl_s.active = (h_cnt_r < H_VIS_C) && (v_cnt_r < V_VIS_C);
        raw_ctl_s.hsync  = !((h_cnt_r >= H_SYN_LO) && (h_cnt_r < H_SYN_HI));
        raw_ctl_s.vsync  = !((v_cnt_r >= V_SYN_LO) && (v_cnt_r < V_SYN_HI));
    end

    // Counters are about to step onto (0, V_VISIBLE).
    assign vblank_entry_s = (h_cnt_r == H_LAST) && (v_cnt_r == V_PRE_VB);

    video_delay_line #(
        .DEPTH       (PIPE_LATENCY),
        .WIDTH       (3),
        .RESET_VALUE (SCAN_CTL_IDLE)
    ) u_ctl_delay (
        .clk    (clk),
        .reset  (reset),
        .pix_en (pix_en),
        .din    (raw_ctl_s),
        .dout   (dly_ctl_s)
    );

    // Output stage: color and syncs registered together so they stay aligned.
    always_ff @(posedge clk) begin
        if (reset) begin
            vga_r       <= 5'd0;
            vga_g       <= 6'd0;
            vga_b       <= 5'd0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            frame_start <= 1'b0;
        end else if (pix_en) begin
            if (dly_ctl_s.active) begin
                vga_r <= color_in[RED_MSB:RED_LSB];
                vga_g <= color_in[GRN_MSB:GRN_LSB];
                vga_b <= color_in[BLU_MSB:BLU_LSB];
            end else begin
                vga_r <= 5'd0;
                vga_g <= 6'd0;
                vga_b <= 5'd0;
            end
            hsync       <= dly_ctl_s.hsync;
            vsync       <= dly_ctl_s.vsync;
            frame_start <= vblank_entry_s;
        end else begin
            frame_start <= 1'b0;
        end
    end

`ifdef VIDEO_SCAN_FRAME_COUNTER_EN
    logic [15:0] frame_count_r;

    // Counts up on the same edge that raises frame_start.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_count_r <= 16'd0;
        end else if (pix_en && vblank_entry_s) begin
            frame_count_r <= frame_count_r + 16'd1;
        end
    end

    assign frame_count = frame_count_r;
`else
    assign frame_count = 16'd0;
`endif

endmodule

// File: tb/tb_video_scan.sv
// Scoreboard bench for video_scan using a reduced raster so whole frames stay short.
module tb_video_scan;

    localparam int HV = 16, HF = 2, HS = 3, HB = 3;
    localparam int VV = 10, VF = 2, VS = 2, VB = 3;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int LAT = 1;
    localparam int CW = 10;

    typedef struct packed {
        logic act;
        logic hs;
        logic vs;
    } pipe_t;

    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic [4:0]    r;
        logic [5:0]    g;
        logic [4:0]    b;
        logic          hs;
        logic          vs;
        logic          fs;
        logic [15:0]   fc;
    } out_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          pix_en = 1'b0;
    logic [15:0]   color_in = 16'd0;
    logic [CW-1:0] x_coord, y_coord;
    logic          frame_start, hsync, vsync;
    logic [4:0]    vga_r, vga_b;
    logic [5:0]    vga_g;
    logic [15:0]   frame_count;

    out_t  obs;
    out_t  expv;
    pipe_t q[$];
    int    mh, mv;
    int    vectors = 0;
    int    miscompares = 0;

    video_scan #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .COORD_WIDTH(CW), .PIPE_LATENCY(LAT)
    ) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .x_coord(x_coord), .y_coord(y_coord), .color_in(color_in),
        .frame_start(frame_start), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .hsync(hsync), .vsync(vsync), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    always_comb obs = {x_coord, y_coord, vga_r, vga_g, vga_b, hsync, vsync, frame_start, frame_count};

    task automatic do_reset(input logic en);
        reset  = 1'b1;
        pix_en = en;
        @(posedge clk); #1;
        reset  = 1'b0;
        pix_en = 1'b0;
        mh = 0;
        mv = 0;
        q.delete();
        for (int i = 0; i < LAT; i++) q.push_back('{act: 1'b0, hs: 1'b1, vs: 1'b1});
        expv = '{x: '0, y: '0, r: 5'd0, g: 6'd0, b: 5'd0, hs: 1'b1, vs: 1'b1, fs: 1'b0, fc: 16'd0};
    endtask

    // Drive one clk and advance the reference model; expected outputs land in expv.
    task automatic step(input logic en, input logic [15:0] col);
        pipe_t p;
        logic  fs_next;
        pix_en   = en;
        color_in = col;
        fs_next  = 1'b0;
        if (en) begin
            p.act = (mh < HV) && (mv < VV);
            p.hs  = !((mh >= HV + HF) && (mh < HV + HF + HS));
            p.vs  = !((mv >= VV + VF) && (mv < VV + VF + VS));
            q.push_back(p);
            fs_next = (mh == HT - 1) && (mv == VV - 1);
        end
        @(posedge clk); #1;
        if (en) begin
            p = q.pop_front();
            expv.r  = p.act ? col[15:11] : 5'd0;
            expv.g  = p.act ? col[10:5]  : 6'd0;
            expv.b  = p.act ? col[4:0]   : 5'd0;
            expv.hs = p.hs;
            expv.vs = p.vs;
            expv.fs = fs_next;
`ifdef VIDEO_SCAN_FRAME_COUNTER_EN
            if (fs_next) expv.fc = expv.fc + 16'd1;
`endif
            if (mh == HT - 1) begin
                mh = 0;
                mv = (mv == VT - 1) ? 0 : mv + 1;
            end else begin
                mh = mh + 1;
            end
            expv.x = CW'(mh);
            expv.y = CW'(mv);
        end else begin
            expv.fs = 1'b0;
        end
    endtask

    task automatic test_reset();
        do_reset(1'b1);
        vectors++;
        if (obs !== expv) begin
            miscompares++;
            $display("FAIL reset_state: got %h expected %h", obs, expv);
        end
        vectors++;
        if (x_coord !== 10'd0 || y_coord !== 10'd0 || hsync !== 1'b1 || vsync !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_pins: got x=%0d y=%0d hs=%b vs=%b expected 0 0 1 1", x_coord, y_coord, hsync, vsync);
        end
    endtask

    task automatic test_full_frame();
        int fs_cnt = 0, hs_lo = 0, vs_lo = 0, ywrap = 0, xwrap_bad = 0;
        logic [CW-1:0] px, py;
        do_reset(1'b1);
        for (int t = 0; t < FRAME; t++) begin
            px = x_coord;
            py = y_coord;
            step(1'b1, 16'($urandom));
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL frame_tick_%0d: got %h expected %h", t, obs, expv);
            end
            if (px == 10'(HT - 1) && x_coord !== 10'd0) xwrap_bad++;
            if (py == 10'(VT - 1) && y_coord == 10'd0) ywrap++;
            if (!hsync) hs_lo++;
            if (!vsync) vs_lo++;
            if (frame_start) begin
                fs_cnt++;
                vectors++;
                if (x_coord !== 10'd0 || y_coord !== 10'(VV)) begin
                    miscompares++;
                    $display("FAIL frame_start_pos: got (%0d,%0d) expected (0,%0d)", x_coord, y_coord, VV);
                end
            end
        end
        vectors++;
        if (fs_cnt != 1) begin
            miscompares++;
            $display("FAIL frame_start_count: got %0d expected 1", fs_cnt);
        end
        vectors++;
        if (ywrap != 1 || xwrap_bad != 0) begin
            miscompares++;
            $display("FAIL coord_wrap: got ywrap=%0d xbad=%0d expected 1 0", ywrap, xwrap_bad);
        end
        vectors++;
        if (hs_lo != HS * VT || vs_lo != VS * HT) begin
            miscompares++;
            $display("FAIL sync_width: got hs=%0d vs=%0d expected %0d %0d", hs_lo, vs_lo, HS * VT, VS * HT);
        end
    endtask

    task automatic test_red_latency();
        do_reset(1'b1);
        step(1'b1, 16'hF800);
        vectors++;
        if (vga_r !== 5'd0) begin
            miscompares++;
            $display("FAIL red_tick1: got %0d expected 0", vga_r);
        end
        step(1'b1, 16'hF800);
        vectors++;
        if (vga_r !== 5'd31 || vga_g !== 6'd0 || vga_b !== 5'd0) begin
            miscompares++;
            $display("FAIL red_tick2: got r=%0d g=%0d b=%0d expected 31 0 0", vga_r, vga_g, vga_b);
        end
        for (int t = 0; t < 3 * HT; t++) begin
            step(1'b1, 16'hF800);
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL red_scan_%0d: got %h expected %h", t, obs, expv);
            end
        end
    endtask

    task automatic test_half_rate();
        int clks = 0, first = -1, second = -1;
        do_reset(1'b1);
        for (int t = 0; t < 1400 && second < 0; t++) begin
            step(t[0] == 1'b0, 16'($urandom));
            clks++;
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL half_rate_%0d: got %h expected %h", t, obs, expv);
            end
            if (frame_start) begin
                if (first < 0) first = clks;
                else second = clks;
            end
        end
        vectors++;
        if (second - first != 2 * FRAME || first < 0) begin
            miscompares++;
            $display("FAIL half_rate_period: got %0d expected %0d", second - first, 2 * FRAME);
        end
    endtask

    task automatic test_mid_reset();
        int n = 0, guard = 0;
        do_reset(1'b1);
        while (!(mh == 10 && mv == 5) && guard < 2 * FRAME) begin
            step(1'b1, 16'($urandom));
            guard++;
        end
        do_reset(1'b1);
        vectors++;
        if (obs !== expv) begin
            miscompares++;
            $display("FAIL mid_reset: got %h expected %h", obs, expv);
        end
        while (!frame_start && n < 2 * FRAME) begin
            step(1'b1, 16'($urandom));
            n++;
        end
        vectors++;
        if (n != VV * HT) begin
            miscompares++;
            $display("FAIL mid_reset_first_fs: got %0d ticks expected %0d", n, VV * HT);
        end
    endtask

    task automatic test_frame_count();
        logic [15:0] want;
`ifdef VIDEO_SCAN_FRAME_COUNTER_EN
        want = 16'd3;
`else
        want = 16'd0;
`endif
        do_reset(1'b1);
        for (int t = 0; t < 3 * FRAME; t++) begin
            step(1'b1, 16'($urandom));
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL fc_scan_%0d: got %h expected %h", t, obs, expv);
            end
        end
        vectors++;
        if (frame_count !== want) begin
            miscompares++;
            $display("FAIL frame_count: got %0d expected %0d", frame_count, want);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_red_latency();
        test_half_rate();
        test_mid_reset();
        test_frame_count();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/video_scan.md
VIDEO_SCAN -- requirements
Module: video_scan

Interface
REQ-001 Parameter H_VISIBLE, default 640, visible pixels per line.
REQ-002 Parameters H_FRONT/H_SYNC/H_BACK, defaults 16/96/48, horizontal porch and sync widths in pixels.
REQ-003 Parameter V_VISIBLE, default 480, visible lines per frame.
REQ-004 Parameters V_FRONT/V_SYNC/V_BACK, defaults 10/2/33, vertical porch and sync widths in lines.
REQ-005 Parameter COORD_WIDTH, default 10, width of the coordinate outputs and counters.
REQ-006 Parameter PIPE_LATENCY, default 1, range 0..4, pixel ticks between coordinate out and valid color_in.
REQ-007 clk  in  1  system clock.
REQ-008 reset  in  1  synchronous, active-high.
REQ-009 pix_en  in  1  pixel tick; all scan state advances only on clk edges with pix_en=1.
REQ-010 x_coord  out  COORD_WIDTH  current horizontal count, to renderer.
REQ-011 y_coord  out  COORD_WIDTH  current vertical count, to renderer.
REQ-012 color_in  in  16  RGB565 pixel from renderer, valid PIPE_LATENCY ticks after its coordinate.
REQ-013 frame_start  out  1  one-clk pulse at vblank start, drives renderer copy_start.
REQ-014 vga_r/vga_g/vga_b  out  5/6/5  registered pixel color.
REQ-015 hsync/vsync  out  1/1  active-low syncs.
REQ-016 frame_count  out  16  frames completed (see Configuration).

Function
REQ-017 h_cnt counts 0..H_TOTAL-1 (H_TOTAL = sum of H_* parameters), wraps to 0 and increments v_cnt on wrap.
REQ-018 v_cnt counts 0..V_TOTAL-1 and wraps to 0 together with the h_cnt wrap at (H_TOTAL-1, V_TOTAL-1).
REQ-019 x_coord=h_cnt, y_coord=v_cnt, combinational from counters, no blanking clamp.
REQ-020 Region: active = h_cnt<H_VISIBLE and v_cnt<V_VISIBLE.
REQ-021 Raw hsync is low for H_VISIBLE+H_FRONT <= h_cnt < H_VISIBLE+H_FRONT+H_SYNC.
REQ-022 Raw vsync is low for V_VISIBLE+V_FRONT <= v_cnt < V_VISIBLE+V_FRONT+V_SYNC.
REQ-023 Raw active/hsync/vsync pass through a PIPE_LATENCY-deep shift line advanced only on pix_en; PIPE_LATENCY=0 means no delay.
REQ-024 On pix_en the output register loads {vga_r,vga_g,vga_b} from color_in[15:11]/[10:5]/[4:0] when delayed active=1, else all zero.
REQ-025 hsync/vsync outputs are registered in the same stage as color, so all three stay aligned.
REQ-026 frame_start pulses for exactly one clk, on the pix_en edge where counters step to (h=0, v=V_VISIBLE).
REQ-027 pix_en=0 holds every register, including frame_start=0.
REQ-028 pix_en held high continuously is legal: one pixel per clk.
REQ-029 Total output latency from counter value to pins is PIPE_LATENCY+1 pixel ticks.

Reset
REQ-030 Reset sets h_cnt=0, v_cnt=0, shift line to inactive (active=0, syncs=1), colors=0, hsync=vsync=1, frame_start=0, frame_count=0.
REQ-031 Reset mid-frame takes priority over pix_en; scan restarts at (0,0) on the next tick and the first frame_start follows after V_VISIBLE lines.

Configuration
REQ-032 With VIDEO_SCAN_FRAME_COUNTER_EN defined, frame_count increments (wrapping at 16 bits) in the clk that frame_start is asserted.
REQ-033 Without the macro, frame_count is tied to 0 and no counter register exists.

Structure
REQ-034 A shared package video_timing_pkg holds the default timing constants, H_TOTAL/V_TOTAL derivations and the RGB565 field-slice constants.
REQ-035 One sub-module, video_delay_line (parameterised depth and width, pix_en-qualified), implements REQ-023.

Verification
REQ-036 Reset, pix_en=1 for 800x525 clks -> exactly one frame_start, at h=0, v=480; x_coord wraps 799->0 and y_coord wraps 524->0.
REQ-037 PIPE_LATENCY=1, color_in=16'hF800 always -> vga_r=31 during active pixels only; the first non-zero pixel appears 2 ticks after (0,0).
REQ-038 Scan full frame -> hsync low for 96 ticks starting 656 ticks into each line; vsync low for lines 490..491.
REQ-039 pix_en asserted every 2nd clk -> all outputs hold on idle clks; frame period is 2x800x525 clks; frame_start stays 1 clk wide.
REQ-040 Reset asserted at h=300, v=200 -> next tick reports x=0, y=0, outputs blanked, hsync=vsync=1.
REQ-041 With VIDEO_SCAN_FRAME_COUNTER_EN defined, after 3 frames frame_count=3; without the macro, frame_count=0 throughout.
